serial_out_buffer: RTL and testbench

- Parametrised parallel-in/serial-out buffer; successor to the fixed 8-bit load-and-shift register.
- Accepts words over a valid/ready handshake and holds one pending word in a holding register, so consecutive words serialise gaplessly.
- Serialises each word MSB-first or LSB-first, one bit per enabled cycle, with valid, last and done flags.
- Sits between a parallel word producer and a bit-serial output stage (line driver, serial link).

---
 rtl/serial_out_buffer.sv | 112 +++++++++++
 tb/tb_serial_out_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_out_buffer.sv
// Parallel-in/serial-out buffer with a one-word holding register, so back-to-back
// words leave the serial output without a gap.
module serial_out_buffer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] vect_in,
    input  logic             load_in,
    output logic             ready_out,
    input  logic             shift_en_in,
    input  logic             abort_in,
    output logic             ser_out,
    output logic             ser_valid_out,
    output logic             last_out,
    output logic             done_out,
    output logic [WIDTH-1:0] vect_out,
    output logic             busy_out
);

    // state | meaning
    // IDLE  | no word in sr, serial output masked
    // SHIFT | sr holds the word being serialised, cnt = bits already consumed
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [WIDTH-1:0] vect_q;

    logic             accept;
    logic             final_bit;
    logic [WIDTH-1:0] sr_shifted;

    assign ready_out  = rst_in && !hold_full_q;
    assign accept     = load_in && ready_out && !abort_in;
    assign final_bit  = (state_q == SHIFT) && shift_en_in && (cnt_q == LAST_CNT);
    assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

    assign busy_out      = (state_q == SHIFT);
    assign ser_valid_out = busy_out;
    assign ser_out       = busy_out && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
    assign last_out      = busy_out && (cnt_q == LAST_CNT);
    assign done_out      = done_q;
    assign vect_out      = vect_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            vect_q      <= '0;
        end else begin
            done_q <= 1'b0;
            vect_q <= sr_q;
            if (abort_in) begin
                state_q     <= IDLE;
                sr_q        <= '0;
                hold_q      <= '0;
                hold_full_q <= 1'b0;
                cnt_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            sr_q    <= vect_in;
                            cnt_q   <= '0;
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (shift_en_in) begin
                            if (cnt_q != LAST_CNT) begin
                                sr_q  <= sr_shifted;
                                cnt_q <= cnt_q + 1'b1;
                            end else if (hold_full_q) begin
                                sr_q        <= hold_q;
                                hold_full_q <= 1'b0;
                                cnt_q       <= '0;
                            end else if (accept) begin
                                // Word arriving on the final bit skips the holding register.
                                sr_q  <= vect_in;
                                cnt_q <= '0;
                            end else begin
                                sr_q    <= '0;
                                cnt_q   <= '0;
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                        if (accept && !final_bit) begin
                            hold_q      <= vect_in;
                            hold_full_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_out_buffer.sv
// Directed bench for serial_out_buffer: an MSB-first and an LSB-first instance.
module tb_serial_out_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, shift, abort;
    logic [7:0] vect;
    logic       ready, ser, sval, last, done, busy;
    logic [7:0] vout;

    logic       l_load, l_shift, l_abort;
    logic [7:0] l_vect;
    logic       l_ready, l_ser, l_sval, l_last, l_done, l_busy;
    logic [7:0] l_vout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_out_buffer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(3)) u_msb (
        .clk_in(clk), .rst_in(rst), .vect_in(vect), .load_in(load), .ready_out(ready),
        .shift_en_in(shift), .abort_in(abort), .ser_out(ser), .ser_valid_out(sval),
        .last_out(last), .done_out(done), .vect_out(vout), .busy_out(busy)
    );

    serial_out_buffer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(3)) u_lsb (
        .clk_in(clk), .rst_in(rst), .vect_in(l_vect), .load_in(l_load), .ready_out(l_ready),
        .shift_en_in(l_shift), .abort_in(l_abort), .ser_out(l_ser), .ser_valid_out(l_sval),
        .last_out(l_last), .done_out(l_done), .vect_out(l_vout), .busy_out(l_busy)
    );

    typedef struct {
        logic       load;
        logic [7:0] vect;
        logic [5:0] flags;   // {ready, ser, sval, last, done, busy}
        logic [7:0] vo;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [7:0] v, input logic [5:0] f, input logic [7:0] vo);
        vec_t e;
        e.load = ld; e.vect = v; e.flags = f; e.vo = vo;
        tbl.push_back(e);
    endtask

    initial begin
        logic [15:0] stream;
        int          vcnt, rdy_cnt, done_cnt, errs, busy_cnt;

        // load A5, shift every cycle: bits 1,0,1,0,0,1,0,1
        add(1'b1, 8'hA5, 6'b100000, 8'h00);
        add(1'b0, 8'h00, 6'b111001, 8'h00);
        add(1'b0, 8'h00, 6'b101001, 8'hA5);
        add(1'b0, 8'h00, 6'b111001, 8'h4A);
        add(1'b0, 8'h00, 6'b101001, 8'h94);
        add(1'b0, 8'h00, 6'b101001, 8'h28);
        add(1'b0, 8'h00, 6'b111001, 8'h50);
        add(1'b0, 8'h00, 6'b101001, 8'hA0);
        add(1'b0, 8'h00, 6'b111101, 8'h40);
        add(1'b0, 8'h00, 6'b100010, 8'h80);
        add(1'b0, 8'h00, 6'b100000, 8'h00);

        rst = 1'b0; load = 1'b0; vect = 8'h00; shift = 1'b1; abort = 1'b0;
        l_load = 1'b0; l_vect = 8'h00; l_shift = 1'b0; l_abort = 1'b0;
        #1;
        step(); step();
        chk("reset_msb_flags", {26'd0, ready, ser, sval, last, done, busy}, 32'd0);
        chk("reset_msb_vect", {24'd0, vout}, 32'd0);
        chk("reset_lsb_flags", {26'd0, l_ready, l_ser, l_sval, l_last, l_done, l_busy}, 32'd0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            load = tbl[i].load;
            vect = tbl[i].vect;
            #1;
            chk($sformatf("tbl%0d_flags", i), {26'd0, ready, ser, sval, last, done, busy},
                {26'd0, tbl[i].flags});
            chk($sformatf("tbl%0d_vect", i), {24'd0, vout}, {24'd0, tbl[i].vo});
            step();
        end
        load = 1'b0;

        // back-to-back F0 then 0F through the holding register
        load = 1'b1; vect = 8'hF0; step();
        vect = 8'h0F;
        stream = '0; vcnt = 0; rdy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) load = 1'b0;
            #1;
            if (i == 0) chk("b2b_ready_second_accept", {31'd0, ready}, 32'd1);
            if (i >= 1 && i <= 7 && !ready) rdy_cnt++;
            if (i == 8) chk("b2b_ready_after_drain", {31'd0, ready}, 32'd1);
            stream[15-i] = ser;
            if (sval) vcnt++;
            if (done) done_cnt++;
            step();
        end
        chk("b2b_stream", {16'd0, stream}, 32'h0000F00F);
        chk("b2b_valid_cycles", vcnt, 16);
        chk("b2b_ready_low_cycles", rdy_cnt, 7);
        chk("b2b_no_early_done", done_cnt, 0);
        #1;
        chk("b2b_done_end", {30'd0, done, sval}, 32'd2);
        step();
        chk("b2b_done_one_cycle", {31'd0, done}, 32'd0);

        // bypass: 81 offered on the final-bit cycle of FF
        load = 1'b1; vect = 8'hFF; step();
        load = 1'b0;
        stream = '0; vcnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin load = 1'b1; vect = 8'h81; end
            if (i == 8) load = 1'b0;
            #1;
            stream[15-i] = ser;
            if (sval) vcnt++;
            if (ready) rdy_cnt++;
            step();
        end
        chk("byp_stream", {16'd0, stream}, 32'h0000FF81);
        chk("byp_valid_cycles", vcnt, 16);
        chk("byp_hold_never_full", rdy_cnt, 16);
        #1;
        chk("byp_done", {31'd0, done}, 32'd1);
        step();

        // abort mid-word with 55 held
        load = 1'b1; vect = 8'hAA; step();
        vect = 8'h55; step();
        #1;
        chk("abt_hold_full", {31'd0, ready}, 32'd0);
        step();
        abort = 1'b1; step();
        #1;
        chk("abt_idle_flags", {26'd0, ready, ser, sval, last, done, busy}, 32'b100000);
        vect = 8'hC3; step();
        abort = 1'b0; load = 1'b0;
        vcnt = 0; done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (sval) vcnt++;
            if (done) done_cnt++;
            step();
        end
        chk("abt_nothing_sent", vcnt, 0);
        chk("abt_no_done", done_cnt, 0);

        // synchronous reset in the middle of a word, load ignored during reset
        load = 1'b1; vect = 8'hA5; step();
        load = 1'b0; step(); step();
        rst = 1'b0; load = 1'b1; vect = 8'hFF;
        #1;
        chk("rst_ready_low", {31'd0, ready}, 32'd0);
        step();
        rst = 1'b1; load = 1'b0;
        #1;
        chk("rst_flags_after", {26'd0, ready, ser, sval, last, done, busy}, 32'b100000);
        chk("rst_vect_after", {24'd0, vout}, 32'd0);
        load = 1'b1; vect = 8'h3C; step();
        load = 1'b0;
        stream = '0; vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            stream[7-i] = ser;
            if (sval) vcnt++;
            if (i == 7) chk("rst_3c_last", {31'd0, last}, 32'd1);
            step();
        end
        chk("rst_3c_stream", {24'd0, stream[7:0]}, 32'h3C);
        chk("rst_3c_valid", vcnt, 8);
        #1;
        chk("rst_3c_done", {31'd0, done}, 32'd1);

        // LSB-first, shift strobe every third cycle
        l_load = 1'b1; l_vect = 8'h01; step();
        l_load = 1'b0;
        errs = 0; busy_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            l_shift = (k % 3 == 2);
            #1;
            if (l_busy) busy_cnt++;
            if (l_ser !== (k < 3)) errs++;
            if (l_last !== (k >= 21 && k <= 23)) errs++;
            if (l_done !== (k == 24)) errs++;
            step();
        end
        chk("lsb_pattern_errors", errs, 0);
        chk("lsb_shift_cycles", busy_cnt, 24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
